// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the fetch-side PC sequencing logic.
package riscv_pipe_pkg;

    localparam int unsigned RISC_V_DATA_WIDTH         = 32;
    localparam int unsigned INST_MEMORY_ADDRESS_WIDTH = 32;
    localparam int unsigned PC_INCREMENT              = 4;

    typedef logic [INST_MEMORY_ADDRESS_WIDTH-1:0] pc_t;

    // S_RUN: sequential fetch, S_HOLD: stalled with a redirect parked,
    // S_BUBBLE: fetch invalid while instruction memory catches up with a new target.
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HOLD   = 2'd1,
        S_BUBBLE = 2'd2
    } pcseq_state_t;

    // Instructions are word aligned; any target with low bits set is rejected.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/ifid_pc_redirect_arb.sv
// Combinational redirect selector: EX beats ID, misaligned targets are
// rejected (flagged) and the next lower-priority source is considered.
module ifid_pc_redirect_arb #(
    parameter int unsigned INST_MEMORY_ADDRESS_WIDTH = 32
) (
    input  logic                                 ex_redirect,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] ex_target,
    input  logic                                 id_taken,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] id_target,
    input  logic                                 id_enable,
    output logic                                 sel_valid,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] sel_pc,
    output logic                                 sel_is_ex,
    output logic                                 misalign
);
    import riscv_pipe_pkg::*;

    logic ex_ok;
    logic id_req;

    assign ex_ok  = ex_redirect && is_aligned(ex_target[1:0]);
    assign id_req = id_enable && id_taken;

    // Priority pick; an accepted EX redirect hides the ID request entirely,
    // so a misaligned ID target is not flagged in that case.
    always_comb begin
        sel_valid = 1'b0;
        sel_pc    = '0;
        sel_is_ex = 1'b0;
        misalign  = 1'b0;
        if (ex_ok) begin
            sel_valid = 1'b1;
            sel_pc    = ex_target;
            sel_is_ex = 1'b1;
        end else begin
            if (ex_redirect) begin
                misalign = 1'b1;
            end
            if (id_req) begin
                if (is_aligned(id_target[1:0])) begin
                    sel_valid = 1'b1;
                    sel_pc    = id_target;
                end else begin
                    misalign = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ifid_pc_sequencer.sv
// Fetch PC owner: arbitrates redirects/stalls, parks redirects during stalls,
// and inserts fetch bubbles after a redirect while memory returns the new line.
// Redirect inputs are single-cycle requests sampled every clock; there is no
// back-pressure, a request not captured in its cycle is lost by design.
module ifid_pc_sequencer #(
    parameter int unsigned INST_MEMORY_ADDRESS_WIDTH = 32,
    parameter int unsigned RISC_V_DATA_WIDTH         = 32,
    parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned BUBBLE_CYCLES             = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 stall_i,
    input  logic                                 id_br_taken_i,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] id_pc_i,
    input  logic [RISC_V_DATA_WIDTH-1:0]         id_offset_i,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] adder_target_i,
    input  logic                                 ex_redirect_i,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] ex_target_i,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] adder_pc_o,
    output logic [RISC_V_DATA_WIDTH-1:0]         adder_offset_o,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] pc_o,
    output logic                                 fetch_valid_o,
    output logic                                 flush_ifid_o,
    output logic                                 flush_idex_o,
    output logic                                 misalign_o,
    output logic [1:0]                           dbg_state
);
    import riscv_pipe_pkg::*;

    localparam int unsigned AW = INST_MEMORY_ADDRESS_WIDTH;

    pcseq_state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    logic          pend_is_ex_q, pend_is_ex_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          fv_q, fv_d;
    logic          fl_ifid_q, fl_ifid_d;
    logic          fl_idex_q, fl_idex_d;
    logic          mis_q, mis_d;

    logic          id_enable;
    logic          sel_valid;
    logic [AW-1:0] sel_pc;
    logic          sel_is_ex;
    logic          arb_misalign;

    logic          apply;
    logic [AW-1:0] apply_pc;
    logic          apply_ex;

    // The offset adder lives outside; just hand it the ID operands.
    assign adder_pc_o     = id_pc_i;
    assign adder_offset_o = id_offset_i;

    // ID redirects are masked while a bubble is running and when an EX
    // redirect is already parked (EX must never be displaced by ID).
    assign id_enable = (state_q != S_BUBBLE) &&
                       !((state_q == S_HOLD) && pend_is_ex_q);

    ifid_pc_redirect_arb #(
        .INST_MEMORY_ADDRESS_WIDTH(AW)
    ) u_arb (
        .ex_redirect (ex_redirect_i),
        .ex_target   (ex_target_i),
        .id_taken    (id_br_taken_i),
        .id_target   (adder_target_i),
        .id_enable   (id_enable),
        .sel_valid   (sel_valid),
        .sel_pc      (sel_pc),
        .sel_is_ex   (sel_is_ex),
        .misalign    (arb_misalign)
    );

    // Next-state, next-PC, pending and bubble-counter logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_is_ex_d = pend_is_ex_q;
        cnt_d        = cnt_q;
        fv_d         = fv_q;
        fl_ifid_d    = 1'b0;
        fl_idex_d    = 1'b0;
        mis_d        = arb_misalign;
        apply        = 1'b0;
        apply_pc     = sel_pc;
        apply_ex     = sel_is_ex;

        case (state_q)
            S_RUN, S_BUBBLE: begin
                if (sel_valid) begin
                    if (stall_i) begin
                        pend_pc_d    = sel_pc;
                        pend_is_ex_d = sel_is_ex;
                        state_d      = S_HOLD;
                    end else begin
                        apply = 1'b1;
                    end
                end else if (!stall_i) begin
                    if (state_q == S_RUN) begin
                        // fv_q low in S_RUN only on the first cycle out of reset:
                        // present RESET_PC once before incrementing.
                        if (fv_q) begin
                            pc_d = pc_q + AW'(PC_INCREMENT);
                        end else begin
                            fv_d = 1'b1;
                        end
                    end else begin
                        if (cnt_q <= 2'd1) begin
                            cnt_d   = 2'd0;
                            state_d = S_RUN;
                            fv_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (sel_valid) begin
                    pend_pc_d    = sel_pc;
                    pend_is_ex_d = sel_is_ex;
                end
                if (!stall_i) begin
                    apply    = 1'b1;
                    apply_pc = sel_valid ? sel_pc    : pend_pc_q;
                    apply_ex = sel_valid ? sel_is_ex : pend_is_ex_q;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (apply) begin
            pc_d         = apply_pc;
            fl_ifid_d    = 1'b1;
            fl_idex_d    = apply_ex;
            pend_pc_d    = '0;
            pend_is_ex_d = 1'b0;
            if (BUBBLE_CYCLES > 0) begin
                state_d = S_BUBBLE;
                cnt_d   = 2'(BUBBLE_CYCLES);
                fv_d    = 1'b0;
            end else begin
                state_d = S_RUN;
                cnt_d   = 2'd0;
                fv_d    = 1'b1;
            end
        end
    end

    // State and output registers; reset clears everything with no flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_is_ex_q <= 1'b0;
            cnt_q        <= 2'd0;
            fv_q         <= 1'b0;
            fl_ifid_q    <= 1'b0;
            fl_idex_q    <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_is_ex_q <= pend_is_ex_d;
            cnt_q        <= cnt_d;
            fv_q         <= fv_d;
            fl_ifid_q    <= fl_ifid_d;
            fl_idex_q    <= fl_idex_d;
            mis_q        <= mis_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fv_q;
    assign flush_ifid_o  = fl_ifid_q;
    assign flush_idex_o  = fl_idex_q;
    assign misalign_o    = mis_q;
    assign dbg_state     = state_q;

endmodule
